// File: rtl/mdu_pkg.sv
// Shared encodings and sizes for the EX-stage multiply/divide unit.
// Imported by the iteration step and the unit top.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_ITERS = MDU_WIDTH;
    localparam int MDU_ACC_W = 2 * MDU_WIDTH + 2;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational iteration: shift-add (mult) or restoring
// trial-subtract (div) on an accumulator of {hi, lo}.
module mdu_iter_step
    import mdu_pkg::*;
(
    input  logic [MDU_ACC_W-1:0] acc,
    input  logic [MDU_WIDTH:0]   operand,
    input  logic                 mode_div,
    output logic [MDU_ACC_W-1:0] acc_next
);
    localparam int W = MDU_WIDTH;

    logic [W+1:0] sum;
    logic [W+1:0] rem_sh;
    logic [W+1:0] diff;

    always_comb begin
        sum    = acc[MDU_ACC_W-1:W] + (acc[0] ? {1'b0, operand} : '0);
        rem_sh = {1'b0, acc[2*W-1:W], acc[W-1]};
        diff   = rem_sh - {1'b0, operand};
        acc_next = '0;
        if (!mode_div) begin
            acc_next = {1'b0, sum, acc[W-1:1]};
        end else if (!diff[W+1]) begin
            acc_next = {1'b0, diff[W:0], acc[W-2:0], 1'b1};
        end else begin
            acc_next = {1'b0, rem_sh[W:0], acc[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32x32 MULT/MULTU/DIV/DIVU unit producing {hi,lo}.
// Holds busy during CALC so the hazard unit stalls the pipeline.
module mult_div_unit
    import mdu_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             op,
    input  logic [MDU_WIDTH-1:0]   src_a,
    input  logic [MDU_WIDTH-1:0]   src_b,
    input  logic                   flush,
    output logic                   busy,
    output logic                   done,
    output logic [2*MDU_WIDTH-1:0] prod,
    output logic                   div_by_zero
);
    localparam int W  = MDU_WIDTH;
    localparam int CW = $clog2(MDU_ITERS);

    mdu_state_e           state;
    logic [CW-1:0]        count;
    logic [MDU_ACC_W-1:0] acc;
    logic [MDU_ACC_W-1:0] acc_step;
    logic [MDU_ACC_W-1:0] acc_init;
    logic [W:0]           operand;
    logic [W:0]           operand_init;
    logic [W:0]           mag_a;
    logic [W:0]           mag_b;
    logic [W-1:0]         raw_a;
    logic                 is_div;
    logic                 neg_res;
    logic                 neg_rem;
    logic                 dbz;
    logic                 op_div;
    logic                 op_signed;
    logic                 sign_a;
    logic                 sign_b;
    logic [2*W-1:0]       mag_res;
    logic [2*W-1:0]       result;
    logic [W-1:0]         quo;
    logic [W-1:0]         rem;

    // 33-bit magnitudes keep |0x8000_0000| from wrapping
    always_comb begin
        op_div    = (op == MDU_DIV) || (op == MDU_DIVU);
        op_signed = (op == MDU_MULT) || (op == MDU_DIV);
        sign_a    = op_signed & src_a[W-1];
        sign_b    = op_signed & src_b[W-1];
        mag_a     = sign_a ? -{1'b1, src_a} : {1'b0, src_a};
        mag_b     = sign_b ? -{1'b1, src_b} : {1'b0, src_b};
        acc_init  = '0;
        acc_init[W-1:0] = op_div ? mag_a[W-1:0] : mag_b[W-1:0];
        operand_init    = op_div ? mag_b : mag_a;
    end

    mdu_iter_step u_step (
        .acc      (acc),
        .operand  (operand),
        .mode_div (is_div),
        .acc_next (acc_step)
    );

    always_comb begin
        mag_res = acc_step[2*W-1:0];
        quo     = neg_res ? -acc_step[W-1:0] : acc_step[W-1:0];
        rem     = neg_rem ? -acc_step[2*W-1:W] : acc_step[2*W-1:W];
        result  = '0;
        if (!is_div) begin
            result = neg_res ? -mag_res : mag_res;
        end else if (dbz) begin
            result = {raw_a, {W{1'b1}}};
        end else begin
            result = {rem, quo};
        end
    end

    assign busy = (state == S_CALC);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            count       <= '0;
            acc         <= '0;
            operand     <= '0;
            raw_a       <= '0;
            is_div      <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            dbz         <= 1'b0;
            prod        <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
            count <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_CALC: begin
                    acc   <= acc_step;
                    count <= count + CW'(1);
                    if (count == CW'(MDU_ITERS - 1)) begin
                        state       <= S_DONE;
                        prod        <= result;
                        div_by_zero <= dbz;
                        done        <= 1'b1;
                    end
                end
                // IDLE and DONE both accept a new operation
                default: begin
                    if (start) begin
                        state   <= S_CALC;
                        count   <= '0;
                        acc     <= acc_init;
                        operand <= operand_init;
                        raw_a   <= src_a;
                        is_div  <= op_div;
                        neg_res <= sign_a ^ sign_b;
                        neg_rem <= sign_a;
                        dbz     <= op_div && (src_b == '0);
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with an expected-result queue
// popped on each done pulse.
module tb_mult_div_unit;
    import mdu_pkg::*;

    typedef struct {
        logic [63:0] prod;
        logic        dbz;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [63:0] prod;
    logic        div_by_zero;

    int          tests;
    int          fails;
    exp_t        sb[$];
    logic [63:0] last_prod;

    mult_div_unit dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .prod        (prod),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] ep,
                          input logic ed, input bit push);
        @(negedge clock);
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        if (push) sb.push_back('{ep, ed});
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Called just after the edge that entered CALC
    task automatic wait_done(input string tag);
        int   lat;
        int   bcnt;
        exp_t e;
        lat  = 1;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 200) begin
            @(posedge clock);
            #1;
            lat++;
            if (busy) bcnt++;
        end
        check({tag, ":done_seen"}, 64'(done), 64'd1);
        if (done) begin
            check({tag, ":latency"}, 64'(lat), 64'd33);
            check({tag, ":busy_cycles"}, 64'(bcnt), 64'd32);
            check({tag, ":sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check({tag, ":prod"}, prod, e.prod);
                check({tag, ":dbz"}, 64'(div_by_zero), 64'(e.dbz));
                last_prod = e.prod;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] ep, input logic ed);
        launch(o, a, b, ep, ed, 1'b1);
        wait_done(tag);
        @(posedge clock);
        #1;
        check({tag, ":done_pulse"}, 64'(done), 64'd0);
        check({tag, ":prod_hold"}, prod, ep);
    endtask

    initial begin
        int dcnt;
        tests     = 0;
        fails     = 0;
        last_prod = '0;
        reset     = 1'b0;
        start     = 1'b0;
        flush     = 1'b0;
        op        = MDU_MULT;
        src_a     = '0;
        src_b     = '0;

        #12;
        check("rst:busy", 64'(busy), 64'd0);
        check("rst:done", 64'(done), 64'd0);
        check("rst:prod", prod, 64'd0);
        check("rst:dbz", 64'(div_by_zero), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        run_op("mult_neg3x7", MDU_MULT, 32'hFFFF_FFFD, 32'd7,
               64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
        run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               64'hFFFF_FFFE_0000_0001, 1'b0);
        run_op("mult_minsq", MDU_MULT, 32'h8000_0000, 32'h8000_0000,
               64'h4000_0000_0000_0000, 1'b0);
        run_op("mult_m1m1", MDU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               64'd1, 1'b0);
        run_op("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2,
               {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
        run_op("divu_7_2", MDU_DIVU, 32'd7, 32'd2,
               {32'd1, 32'd3}, 1'b0);
        run_op("div_7_m2", MDU_DIV, 32'd7, 32'hFFFF_FFFE,
               {32'd1, 32'hFFFF_FFFD}, 1'b0);
        run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               {32'd0, 32'h8000_0000}, 1'b0);
        run_op("divu_5_0", MDU_DIVU, 32'd5, 32'd0,
               {32'd5, 32'hFFFF_FFFF}, 1'b1);
        run_op("div_m5_0", MDU_DIV, 32'hFFFF_FFFB, 32'd0,
               {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1'b1);

        // flush mid-CALC: no done, prod untouched
        launch(MDU_MULT, 32'd9, 32'd9, 64'd0, 1'b0, 1'b0);
        repeat (10) @(posedge clock);
        @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        check("flush:busy", 64'(busy), 64'd0);
        check("flush:done", 64'(done), 64'd0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (done) dcnt++;
        end
        check("flush:no_done", 64'(dcnt), 64'd0);
        check("flush:prod", prod, last_prod);

        // async reset mid-CALC
        launch(MDU_MULT, 32'd2, 32'd3, 64'd0, 1'b0, 1'b0);
        repeat (5) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("rstmid:prod", prod, 64'd0);
        check("rstmid:busy", 64'(busy), 64'd0);
        check("rstmid:done", 64'(done), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        run_op("after_rst", MDU_MULT, 32'd2, 32'd3, 64'd6, 1'b0);

        // back-to-back with start held through CALC and DONE
        @(negedge clock);
        op    = MDU_MULTU;
        src_a = 32'd3;
        src_b = 32'd5;
        start = 1'b1;
        sb.push_back('{64'd15, 1'b0});
        @(posedge clock);
        #1;
        op    = MDU_DIVU;
        src_a = 32'd100;
        src_b = 32'd7;
        sb.push_back('{{32'd2, 32'd14}, 1'b0});
        wait_done("b2b_first");
        @(posedge clock);
        #1;
        start = 1'b0;
        check("b2b:busy_again", 64'(busy), 64'd1);
        check("b2b:no_done", 64'(done), 64'd0);
        wait_done("b2b_second");
        @(posedge clock);
        #1;
        check("b2b:idle", 64'(busy), 64'd0);
        check("sb:drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
